// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//   Bit-serial add/subtract sequencer. One external, purely combinational
//   1-bit full-adder cell is time-shared across a WIDTH-bit operation, LSB
//   first. The carry is threaded between bits through a register. The
//   result, carry-out and signed overflow are published with a one-cycle
//   done pulse.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   start, sub, a, b, cin
//                       : request and operands, captured in IDLE or DONE
//                         (sub=1 selects a-b and ignores cin)
//   fa_a, fa_b, fa_cin  : bit-level operands driven to the shared cell
//   fa_sum, fa_cout     : same-cycle results returned by the shared cell
//   busy                : high while the operation is stepping (RUN)
//   done                : one-cycle pulse when sum/cout/ovf are updated
//   sum, cout, ovf      : registered result, carry out of the MSB
//                         (1 = no borrow on subtract), and signed overflow
// ---------------------------------------------------------------------------
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath logic. IDLE and DONE behave identically with
  // respect to start, which is what gives back-to-back operation from DONE.
  // Subtraction is folded into the capture: b is inverted and the carry
  // seeded with 1, so RUN only ever performs an add.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // The cell's sum enters at the MSB; after WIDTH shifts bit 0 of
        // the result has reached the LSB.
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          k_d     = '0;
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          // carry_q is the carry into the MSB while the MSB is on the cell.
          ovf_d   = carry_q ^ fa_cout;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State register. Reset is synchronous and discards any in-flight
  // operation, including the result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The cell sees only zeros outside RUN so its inputs stay quiet.
  assign fa_a   = (state_q == S_RUN) & op_a_q[0];
  assign fa_b   = (state_q == S_RUN) & op_b_q[0];
  assign fa_cin = (state_q == S_RUN) & carry_q;

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_add_seq
//   Directed self-checking bench for serial_add_seq with WIDTH=8. The shared
//   full-adder cell is modelled here as plain combinational logic. Inputs
//   change on the falling edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_sum;
  logic       fa_cout;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int doneCount = 0;
  int lastDoneCycle = 0;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_sum (fa_sum),
    .fa_cout(fa_cout),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  // The external 1-bit full-adder cell.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  // Cycle counter and done-pulse counter used for latency and pulse checks.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (done) doneCount <= doneCount + 1;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and counts and reports it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives an operation request; called at a falling edge.
  task automatic applyStimulus(input logic [7:0] na, input logic [7:0] nb,
                               input logic ncin, input logic nsub);
    a     = na;
    b     = nb;
    cin   = ncin;
    sub   = nsub;
    start = 1'b1;
  endtask

  // Follows a requested operation from the capture edge through DONE,
  // checking the cell drive bit by bit against an independent ripple model
  // and the result against hand-computed values. When poke is set, start is
  // re-asserted with other operands in RUN cycles 3-5. Returns at the
  // falling edge inside the DONE cycle with start low.
  task automatic runAndCheck(input string tag, input logic [7:0] ea,
                             input logic [7:0] eb, input logic ecin,
                             input logic esub, input logic [7:0] expSum,
                             input logic expCout, input logic expOvf,
                             input bit poke);
    logic [7:0] bb;
    logic       c;
    bb = esub ? ~eb : eb;
    c  = esub ? 1'b1 : ecin;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (poke && i >= 2 && i <= 4) begin
        applyStimulus(8'h11, 8'h22, 1'b1, ~esub);
      end else begin
        start = 1'b0;
      end
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " done-in-run"}, 32'(done), 32'd0);
      checkOutput({tag, " fa_a"}, 32'(fa_a), 32'(ea[i]));
      checkOutput({tag, " fa_b"}, 32'(fa_b), 32'(bb[i]));
      checkOutput({tag, " fa_cin"}, 32'(fa_cin), 32'(c));
      c = (ea[i] & bb[i]) | (ea[i] & c) | (bb[i] & c);
    end
    @(negedge clk);
    start = 1'b0;
    lastDoneCycle = cycle;
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busy-in-done"}, 32'(busy), 32'd0);
    checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(expOvf));
    checkOutput({tag, " cell-quiet-done"}, 32'({fa_a, fa_b, fa_cin}), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    int doneBefore;
    int firstDone;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout-ovf", 32'({cout, ovf}), 32'd0);
    checkOutput("reset cell", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle cell", 32'({fa_a, fa_b, fa_cin}), 32'd0);

    $display("[TB] add with signed overflow");
    doneBefore = doneCount;
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    runAndCheck("add5A3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("add5A3C done-pulse", 32'(done), 32'd0);
    checkOutput("add5A3C idle", 32'(busy), 32'd0);
    checkOutput("add5A3C hold sum", 32'(sum), 32'h96);
    checkOutput("add5A3C one done", 32'(doneCount - doneBefore), 32'd1);

    $display("[TB] add wrap and carry-in");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    runAndCheck("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    runAndCheck("add0cin", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] subtract");
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
    runAndCheck("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b1);
    runAndCheck("sub8001", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    $display("[TB] start ignored during RUN");
    doneBefore = doneCount;
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    runAndCheck("poke", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("poke no-rerun", 32'(busy), 32'd0);
    checkOutput("poke single done", 32'(doneCount - doneBefore), 32'd1);

    $display("[TB] back-to-back");
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
    runAndCheck("b2b first", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    firstDone = lastDoneCycle;
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
    runAndCheck("b2b second", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b spacing", 32'(lastDoneCycle - firstDone), 32'd9);
    @(negedge clk);

    $display("[TB] reset mid-operation");
    doneBefore = doneCount;
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst mid busy-before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst mid busy", 32'(busy), 32'd0);
    checkOutput("rst mid done", 32'(done), 32'd0);
    checkOutput("rst mid sum", 32'(sum), 32'd0);
    checkOutput("rst mid cout-ovf", 32'({cout, ovf}), 32'd0);
    checkOutput("rst mid cell", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("rst mid no done", 32'(doneCount - doneBefore), 32'd0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    runAndCheck("after rst", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial add/subtract sequencer that time-shares one external 1-bit full-adder cell across a WIDTH-bit operation. It latches two operands on a start request and steps the shared cell once per clock, LSB first, threading the carry through a register. It then publishes sum, carry-out and signed overflow with a one-cycle done pulse. It sits between a requesting controller and the team's 1-bit adder cell, which stays purely combinational.

## Interface

**Parameters**
- WIDTH, default 8: operand and result width in bits. Legal range is WIDTH ≥ 2.

**Ports**
- clk, input, 1: the single clock. All state changes on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: operation request. Sampled only in IDLE or DONE.
- sub, input, 1: operation select, captured with start. 0 = a+b+cin, 1 = a−b.
- a, input, WIDTH: operand A, captured with start.
- b, input, WIDTH: operand B, captured with start.
- cin, input, 1: carry-in for add, captured with start. Ignored when sub=1.
- fa_a, output, 1: operand bit to the shared cell.
- fa_b, output, 1: operand bit to the shared cell.
- fa_cin, output, 1: carry bit to the shared cell.
- fa_sum, input, 1: sum returned by the shared cell. Combinational in fa_a/fa_b/fa_cin, same cycle.
- fa_cout, input, 1: carry returned by the shared cell. Combinational in fa_a/fa_b/fa_cin, same cycle.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse when the result is valid.
- sum, output, WIDTH: registered result.
- cout, output, 1: carry out of the MSB. For subtract, 1 = no borrow.
- ovf, output, 1: signed overflow, equal to (carry into MSB) XOR (carry out of MSB).

## Operation

**State machine: IDLE, RUN, DONE**
- IDLE → RUN when start=1. On that edge:
  - opA_sr ← a
  - opB_sr ← (sub ? ~b : b)
  - carry ← (sub ? 1 : cin)
  - bit counter k ← 0
- RUN, every edge:
  - The result shift register takes fa_sum in at the MSB and shifts right.
  - carry ← fa_cout.
  - opA_sr and opB_sr shift right.
  - k increments.
- RUN → DONE on the edge where k = WIDTH−1 (the last bit). On that edge:
  - sum ← final shifted result
  - cout ← fa_cout
  - ovf ← carry (the carry into the MSB) XOR fa_cout
- DONE → RUN if start=1, with capture as in IDLE (back-to-back operation). Otherwise DONE → IDLE.
- start is ignored in RUN: no capture and no queuing.

**Cell drive**
- In RUN: fa_a = opA_sr[0], fa_b = opB_sr[0], fa_cin = carry.
- In IDLE and DONE: fa_a, fa_b and fa_cin are all 0.

**Outputs**
- sum, cout and ovf change only on the RUN→DONE edge. They hold through IDLE and through any following RUN until the next DONE.
- busy = (state == RUN).
- done = (state == DONE). done and busy are never high together.

**Arithmetic**
- Modulo 2^WIDTH.
- Subtract is two's complement: a + ~b + 1.

**Reset**
- rst_n=0 at any edge, including mid-RUN:
  - state → IDLE
  - sum=0, cout=0, ovf=0, busy=0, done=0
  - all shift registers, carry and k cleared
- The in-flight operation is discarded without a done pulse.

## Timing

- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..WIDTH: RUN, busy=1. Bit i is on the cell in cycle i+1.
- Cycle WIDTH+1: DONE, done=1, new result visible.
- Latency from start to done is WIDTH+1 cycles.
- Throughput with start held high in DONE is one operation per WIDTH+1 cycles.
- Shared-cell path is combinational: fa_a/fa_b/fa_cin → cell → fa_sum/fa_cout → internal registers, all within one clock period.

## Test plan

All scenarios use WIDTH=8.

1. **Add with signed overflow:** a=0x5A, b=0x3C, cin=0, sub=0, start for 1 cycle → busy in cycles 1–8, done only in cycle 9; sum=0x96, cout=0, ovf=1.
2. **Add wrap:** a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Repeat with a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
3. **Subtract with borrow:** sub=1, a=0x10, b=0x20 → sum=0xF0, cout=0, ovf=0. Repeat with sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1; cin=1 must not change the result.
4. **Start during RUN and back-to-back:**
   - start re-asserted with new operands in cycles 3–5 → ignored; first result unchanged, single done.
   - start held in DONE → second operation's RUN begins the cycle after DONE; second done 9 cycles after the first.
5. **Reset mid-operation:** rst_n=0 in cycle 4 of RUN → next cycle: IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, no done pulse. A new start then completes normally.
6. **Cell drive check:** in IDLE and DONE, fa_a=fa_b=fa_cin=0. In RUN, fa_a and fa_b present a[i] and b[i] (inverted for subtract) in cycle i+1, and fa_cin matches the expected ripple carry.
